// File: rtl/mp_mgmt_target_pkg.sv
// Shared definitions for the management target: register offsets, FSM encoding
// and the halfword write-merge helper.
package mp_mgmt_target_pkg;

  localparam logic [9:0] MGMT_OFS_MCFG    = 10'h000;
  localparam logic [9:0] MGMT_OFS_MVEC    = 10'h001;
  localparam logic [9:0] MGMT_OFS_MEPC    = 10'h002;
  localparam logic [9:0] MGMT_OFS_SCRATCH = 10'h003;
  localparam logic [9:0] MGMT_OFS_PERF    = 10'h040;

  localparam int unsigned MGMT_PERF_NUM = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAck  = 2'd1,
    StResp = 2'd2
  } mgmt_state_e;

  // wen[0] selects bits 15:0, wen[1] selects bits 31:16.
  function automatic logic [31:0] hw_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [1:0]  wen);
    hw_merge = {wen[1] ? new_val[31:16] : old_val[31:16],
                wen[0] ? new_val[15:0]  : old_val[15:0]};
  endfunction

endpackage

// File: rtl/mp_perf_cnt.sv
// One 32-bit event counter with halfword load; a load takes priority over the
// increment so software writes are never lost to a concurrent event.
module mp_perf_cnt
  import mp_mgmt_target_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_inc,
  input  logic [1:0]  i_wen,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_cnt
);

  logic [31:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_cnt <= '0;
    end else if (|i_wen) begin
      r_cnt <= hw_merge(r_cnt, i_wdata, i_wen);
    end else if (i_inc) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/mp_mgmt_target.sv
// Management register target: req/ack command port, core config registers and
// optional performance counters (built only when MP_MGMT_PERF_EN is defined).
module mp_mgmt_target
  import mp_mgmt_target_pkg::*;
#(
  parameter logic [31:0] BASE_ADR = 32'h0000_F000,
  parameter logic [31:0] MVEC_RST = 32'h0000_0000,
  parameter logic        M32_RST  = 1'b0
) (
  input  logic        sys_clk,
  input  logic        sys_rstn,
  input  logic        mgmt_req,
  output logic        mgmt_ack,
  input  logic        mgmt_rwn,
  input  logic [31:0] mgmt_adr,
  input  logic [1:0]  mgmt_wen,
  input  logic [31:0] mgmt_txd,
  output logic        mgmt_rxe,
  output logic [31:0] mgmt_rxd,
  input  logic [7:0]  perf,
  input  logic        mie_set,
  input  logic        trap,
  input  logic [31:0] pc_epc,
  output logic        m32,
  output logic        mie,
  output logic [31:0] mvec,
  output logic [31:0] mepc
);

  mgmt_state_e r_state, w_state_nxt;
  logic        w_latch;

  // Command captured on the IDLE->ACK edge.
  logic        r_rwn;
  logic        r_hit;
  logic [9:0]  r_ofs;
  logic [1:0]  r_wen;
  logic [31:0] r_txd;

  logic        r_m32;
  logic        r_mie;
  logic [31:0] r_mvec;
  logic [31:0] r_mepc;
  logic [31:0] r_scratch;
  logic [31:0] r_rxd;

  logic        w_wr;
  logic [1:0]  w_wen_mcfg;
  logic [1:0]  w_wen_mvec;
  logic [1:0]  w_wen_mepc;
  logic [1:0]  w_wen_scratch;
  logic [31:0] w_rdata;
  logic        w_unused;

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (mgmt_req) begin
          w_state_nxt = StAck;
          w_latch     = 1'b1;
        end
      end
      StAck:   w_state_nxt = r_rwn ? StResp : StIdle;
      StResp:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  assign w_wr          = (r_state == StAck) && !r_rwn && r_hit;
  assign w_wen_mcfg    = (w_wr && (r_ofs == MGMT_OFS_MCFG))    ? r_wen : 2'b00;
  assign w_wen_mvec    = (w_wr && (r_ofs == MGMT_OFS_MVEC))    ? r_wen : 2'b00;
  assign w_wen_mepc    = (w_wr && (r_ofs == MGMT_OFS_MEPC))    ? r_wen : 2'b00;
  assign w_wen_scratch = (w_wr && (r_ofs == MGMT_OFS_SCRATCH)) ? r_wen : 2'b00;

`ifdef MP_MGMT_PERF_EN
  logic [31:0] w_perf_cnt [MGMT_PERF_NUM];
  logic        w_perf_sel;

  assign w_perf_sel = (r_ofs[9:3] == MGMT_OFS_PERF[9:3]);

  for (genvar gi = 0; gi < MGMT_PERF_NUM; gi++) begin : g_perf
    logic [1:0] w_perf_wen;

    assign w_perf_wen = (w_wr && w_perf_sel && (r_ofs[2:0] == 3'(gi))) ? r_wen : 2'b00;

    mp_perf_cnt u_perf_cnt (
      .i_clk   (sys_clk),
      .i_rstn  (sys_rstn),
      .i_inc   (perf[gi]),
      .i_wen   (w_perf_wen),
      .i_wdata (r_txd),
      .o_cnt   (w_perf_cnt[gi])
    );
  end

  assign w_unused = ^mgmt_adr[1:0];
`else
  assign w_unused = ^{mgmt_adr[1:0], perf};
`endif

  // Sampled from pre-update state, so a same-cycle update is not visible.
  always_comb begin
    w_rdata = '0;
    if (r_hit) begin
      case (r_ofs)
        MGMT_OFS_MCFG:    w_rdata = {30'b0, r_mie, r_m32};
        MGMT_OFS_MVEC:    w_rdata = r_mvec;
        MGMT_OFS_MEPC:    w_rdata = r_mepc;
        MGMT_OFS_SCRATCH: w_rdata = r_scratch;
        default: begin
`ifdef MP_MGMT_PERF_EN
          if (w_perf_sel) w_rdata = w_perf_cnt[r_ofs[2:0]];
`endif
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rstn) begin
      r_state   <= StIdle;
      r_rwn     <= 1'b0;
      r_hit     <= 1'b0;
      r_ofs     <= '0;
      r_wen     <= '0;
      r_txd     <= '0;
      r_rxd     <= '0;
      r_m32     <= M32_RST;
      r_mie     <= 1'b0;
      r_mvec    <= MVEC_RST;
      r_mepc    <= '0;
      r_scratch <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_rwn <= mgmt_rwn;
        r_hit <= (mgmt_adr[31:12] == BASE_ADR[31:12]);
        r_ofs <= mgmt_adr[11:2];
        r_wen <= mgmt_wen;
        r_txd <= mgmt_txd;
      end
      r_rxd <= ((r_state == StAck) && r_rwn) ? w_rdata : 32'h0;

      if (w_wen_mcfg[0]) r_m32 <= r_txd[0];
      // trap beats mie_set, which beats a software write of mie.
      if (trap) begin
        r_mie <= 1'b0;
      end else if (mie_set) begin
        r_mie <= 1'b1;
      end else if (w_wen_mcfg[0]) begin
        r_mie <= r_txd[1];
      end

      r_mvec    <= hw_merge(r_mvec, r_txd, w_wen_mvec);
      r_mepc    <= trap ? pc_epc : hw_merge(r_mepc, r_txd, w_wen_mepc);
      r_scratch <= hw_merge(r_scratch, r_txd, w_wen_scratch);
    end
  end

  assign mgmt_ack = (r_state == StAck);
  assign mgmt_rxe = (r_state == StResp);
  assign mgmt_rxd = r_rxd;
  assign m32      = r_m32;
  assign mie      = r_mie;
  assign mvec     = r_mvec;
  assign mepc     = r_mepc;

endmodule
